// File: rtl/calc1_port_driver.sv
// calc1_port_driver: request FIFO plus a send/wait sequencer
// for one requester port of the CALC1 calculator.
module calc1_port_driver #(
  parameter int DEPTH    = 4,
  parameter int TIMEOUT  = 31,
  parameter int DATA_LAG = 0
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_cmd,
  input  logic [31:0] req_op1,
  input  logic [31:0] req_op2,
  input  logic [1:0]  req_tag,
  output logic [3:0]  cmd_out,
  output logic [31:0] data_out,
  input  logic [1:0]  resp_in,
  input  logic [31:0] resp_data_in,
  output logic        rsp_valid,
  output logic [1:0]  rsp_code,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_tag,
  output logic        rsp_timeout,
  output logic        busy,
  output logic        stray_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [7:0] TMO = 8'(TIMEOUT);

  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  tag;
  } req_t;

  typedef enum logic [2:0] {
    IDLE,
    SEND1,
    SEND2,
    WAIT,
    CAPTURE
  } state_t;

  req_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  req_t          cur;
  state_t        state;
  state_t        state_nxt;
  logic [7:0]    wait_cnt;
  logic [1:0]    code_q;
  logic          push;
  logic          pop;
  logic          resp_hit;
  logic          tmo_hit;

  assign req_ready = (count != CNT_FULL);
  assign push      = req_valid && req_ready;
  assign pop       = (state == IDLE) && (count != '0);
  assign resp_hit  = (resp_in != 2'd0);
  assign tmo_hit   = ((wait_cnt + 8'd1) == TMO);
  assign busy      = (state != IDLE) || (count != '0);

  // FIFO storage: written on an accepted request, never reset.
  always_ff @(posedge c_clk) begin
    if (push) begin
      mem[wr_ptr] <= '{req_cmd, req_op1, req_op2, req_tag};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + (AW+1)'(1);
      end else if (pop && !push) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

  // Request in flight, captured as it leaves the FIFO head.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      cur <= '0;
    end else if (pop) begin
      cur <= mem[rd_ptr];
    end
  end

  // FSM state register.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state; a response in the final WAIT cycle beats timeout.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          state_nxt = SEND1;
        end
      end
      SEND1: state_nxt = SEND2;
      SEND2: state_nxt = WAIT;
      WAIT: begin
        if (resp_hit) begin
          state_nxt = (DATA_LAG != 0) ? CAPTURE : IDLE;
        end else if (tmo_hit) begin
          state_nxt = IDLE;
        end
      end
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: calculator bus is only driven in the two send beats.
  always_comb begin
    cmd_out  = 4'd0;
    data_out = 32'd0;
    unique case (1'b1)
      (state == SEND1): begin
        cmd_out  = cur.cmd;
        data_out = cur.op1;
      end
      (state == SEND2): begin
        data_out = cur.op2;
      end
      default: begin
        cmd_out  = 4'd0;
        data_out = 32'd0;
      end
    endcase
  end

  // Wait counter: cleared in SEND2, counts idle WAIT cycles.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state == SEND2) begin
      wait_cnt <= '0;
    end else if (state == WAIT && !resp_hit) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Completion register: one-cycle pulse, payload held between pulses.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_code    <= '0;
      rsp_data    <= '0;
      rsp_tag     <= '0;
      code_q      <= '0;
    end else begin
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      if (state == WAIT) begin
        if (resp_hit) begin
          if (DATA_LAG == 0) begin
            rsp_valid <= 1'b1;
            rsp_code  <= resp_in;
            rsp_data  <= resp_data_in;
            rsp_tag   <= cur.tag;
          end else begin
            code_q <= resp_in;
          end
        end else if (tmo_hit) begin
          rsp_valid   <= 1'b1;
          rsp_timeout <= 1'b1;
          rsp_code    <= 2'd0;
          rsp_data    <= 32'd0;
          rsp_tag     <= cur.tag;
        end
      end
      if (state == CAPTURE) begin
        rsp_valid <= 1'b1;
        rsp_code  <= code_q;
        rsp_data  <= resp_data_in;
        rsp_tag   <= cur.tag;
      end
    end
  end

  // Sticky flag for responses arriving when none is expected.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      stray_err <= 1'b0;
    end else if (resp_hit &&
                 (state == IDLE || state == SEND1 ||
                  state == SEND2)) begin
      stray_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_calc1_port_driver.sv
// Bench for calc1_port_driver: two lanes (DATA_LAG 0 and 1),
// each with a modelled calculator and a response scoreboard.
`timescale 1ns/1ps
module tb_calc1_port_driver;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 31;
  localparam int NRAND   = 40;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  tag;
  } req_s;

  typedef struct {
    logic [1:0]  code;
    logic [31:0] data;
    logic [1:0]  tag;
    logic        tmo;
    int          at;
  } exp_s;

  typedef struct {
    int          d;
    logic [1:0]  code;
    logic [31:0] data;
  } frc_s;

  logic c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge c_clk) cyc <= cyc + 1;

  function automatic void chk(int lane, string name,
                              logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL lane%0d %s act=%h exp=%h", lane, name, act, exp);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_cmd;
    logic [31:0] req_op1;
    logic [31:0] req_op2;
    logic [1:0]  req_tag;
    logic [3:0]  cmd_out;
    logic [31:0] data_out;
    logic [1:0]  resp_in;
    logic [1:0]  resp_drv;
    logic [1:0]  poke;
    logic [31:0] resp_data_in;
    logic        rsp_valid;
    logic [1:0]  rsp_code;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_tag;
    logic        rsp_timeout;
    logic        busy;
    logic        stray_err;
    logic        rst_q;
    bit          in_wait;
    bit          done;
    int          n_acc;
    int          n_done;
    int          last_rsp_cyc;
    req_s        pend_q[$];
    exp_s        exp_q[$];
    frc_s        force_q[$];

    assign resp_in = resp_drv | poke;
    always @(posedge c_clk) rst_q <= reset;

    calc1_port_driver #(
      .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .DATA_LAG(g)
    ) dut (
      .c_clk(c_clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_cmd(req_cmd), .req_op1(req_op1),
      .req_op2(req_op2), .req_tag(req_tag),
      .cmd_out(cmd_out), .data_out(data_out),
      .resp_in(resp_in), .resp_data_in(resp_data_in),
      .rsp_valid(rsp_valid), .rsp_code(rsp_code),
      .rsp_data(rsp_data), .rsp_tag(rsp_tag),
      .rsp_timeout(rsp_timeout), .busy(busy),
      .stray_err(stray_err)
    );

    // Calculator model: answers each issued request after a chosen delay.
    initial begin : responder
      req_s r;
      exp_s e;
      frc_s f;
      int   c1;
      int   sel;
      bit   aborted;
      resp_drv = 2'd0;
      resp_data_in = 32'd0;
      in_wait = 0;
      forever begin
        @(negedge c_clk);
        resp_drv = 2'd0;
        resp_data_in = $urandom;
        if (!rst_q && !reset && cmd_out != 4'd0) begin
          c1 = cyc;
          if (pend_q.size() == 0) begin
            chk(g, "send_unexpected", 64'(cmd_out), 64'd0);
          end else begin
            r = pend_q.pop_front();
            chk(g, "send1", {28'd0, cmd_out, data_out},
                {28'd0, r.cmd, r.op1});
            if (force_q.size() != 0) begin
              f = force_q.pop_front();
            end else begin
              sel = $urandom_range(0, 9);
              f.code = 2'($urandom_range(1, 3));
              f.data = $urandom;
              if (sel <= 5) f.d = $urandom_range(0, 3);
              else if (sel == 6) f.d = TIMEOUT - 1;
              else if (sel == 7) f.d = TIMEOUT;
              else f.d = $urandom_range(4, TIMEOUT - 2);
            end
            @(negedge c_clk);
            resp_data_in = $urandom;
            chk(g, "send2", {28'd0, cmd_out, data_out},
                {28'd0, 4'd0, r.op2});
            e.tag = r.tag;
            if (f.d >= TIMEOUT) begin
              e.code = 2'd0;
              e.data = 32'd0;
              e.tmo = 1'b1;
              e.at = c1 + 2 + TIMEOUT;
            end else begin
              e.code = f.code;
              e.data = f.data;
              e.tmo = 1'b0;
              e.at = c1 + 3 + f.d + g;
            end
            exp_q.push_back(e);
            in_wait = 1;
            aborted = 0;
            for (int k = 1; k <= f.d + 1 && k <= TIMEOUT; k++) begin
              @(negedge c_clk);
              resp_drv = 2'd0;
              resp_data_in = $urandom;
              if (reset) begin
                aborted = 1;
                break;
              end
              if (k == f.d + 1) begin
                resp_drv = f.code;
                if (g == 0) resp_data_in = f.data;
              end
            end
            if (!aborted && f.d < TIMEOUT && g == 1) begin
              @(negedge c_clk);
              resp_drv = 2'd0;
              resp_data_in = f.data;
            end
            in_wait = 0;
          end
        end else if (!rst_q && cmd_out == 4'd0 && data_out != 32'd0) begin
          chk(g, "idle_bus", 64'(data_out), 64'd0);
        end
      end
    end

    // Scoreboard monitor: every completion pops one expectation.
    initial begin : monitor
      exp_s e;
      logic [35:0] last;
      last = '0;
      n_done = 0;
      last_rsp_cyc = 0;
      forever begin
        @(negedge c_clk);
        if (rst_q) last = '0;
        if (rsp_valid) begin
          if (exp_q.size() == 0) begin
            chk(g, "rsp_unexpected", {rsp_timeout, rsp_code, rsp_data}, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk(g, "rsp_fields",
                {29'd0, rsp_timeout, rsp_code, rsp_tag, rsp_data},
                {29'd0, e.tmo, e.code, e.tag, e.data});
            chk(g, "rsp_cycle", 64'(cyc), 64'(e.at));
            last = {e.code, e.tag, e.data};
            last_rsp_cyc = cyc;
            n_done++;
          end
        end else if (!rst_q) begin
          chk(g, "rsp_hold", {28'd0, rsp_code, rsp_tag, rsp_data},
              {28'd0, last});
        end
      end
    end

    task automatic cycles(int n);
      repeat (n) begin
        @(posedge c_clk);
        #1;
      end
    endtask

    task automatic send_req(logic [3:0] c, logic [31:0] a,
                            logic [31:0] b, logic [1:0] t);
      bit acc;
      req_s r;
      acc = 0;
      req_valid = 1'b1;
      req_cmd = c;
      req_op1 = a;
      req_op2 = b;
      req_tag = t;
      for (int i = 0; i < 300 && !acc; i++) begin
        @(negedge c_clk);
        acc = req_ready;
        @(posedge c_clk);
        #1;
      end
      req_valid = 1'b0;
      if (acc) begin
        r = '{c, a, b, t};
        pend_q.push_back(r);
        n_acc++;
      end else begin
        chk(g, "req_stuck", 64'd0, 64'd1);
      end
    endtask

    task automatic drain();
      for (int i = 0; i < 3000 && n_done != n_acc; i++) cycles(1);
      chk(g, "drain", 64'(n_done), 64'(n_acc));
      cycles(2);
    endtask

    task automatic reach_wait();
      for (int i = 0; i < 100 && !in_wait; i++) cycles(1);
      chk(g, "reach_wait", 64'(in_wait), 64'd1);
    endtask

    // Directed scenarios followed by a randomized stream.
    initial begin : main
      frc_s f;
      req_s r;
      int   c0;
      done = 0;
      n_acc = 0;
      reset = 1'b1;
      req_valid = 1'b0;
      req_cmd = '0;
      req_op1 = '0;
      req_op2 = '0;
      req_tag = '0;
      poke = 2'd0;
      cycles(3);
      chk(g, "rst_ready_busy",
          {60'd0, req_ready, busy, stray_err, rsp_valid}, 64'h8);
      chk(g, "rst_rsp", {27'd0, rsp_timeout, rsp_code, rsp_tag, rsp_data},
          64'd0);
      chk(g, "rst_bus", {28'd0, cmd_out, data_out}, 64'd0);
      reset = 1'b0;
      cycles(2);

      f = '{0, 2'd1, 32'd12};
      force_q.push_back(f);
      c0 = cyc;
      send_req(4'd1, 32'd5, 32'd7, 2'd2);
      drain();
      chk(g, "latency", 64'(last_rsp_cyc - c0), 64'(5 + g));

      f = '{20, 2'd3, 32'h1234_5678};
      force_q.push_back(f);
      send_req(4'd9, $urandom, $urandom, 2'd1);
      reach_wait();
      cycles(1);
      for (int i = 0; i <= DEPTH; i++) begin
        r = '{4'($urandom_range(1, 15)), $urandom, $urandom, 2'($urandom)};
        req_valid = 1'b1;
        req_cmd = r.cmd;
        req_op1 = r.op1;
        req_op2 = r.op2;
        req_tag = r.tag;
        @(negedge c_clk);
        chk(g, $sformatf("fill_ready%0d", i), 64'(req_ready),
            64'(i < DEPTH));
        if (i < DEPTH) begin
          pend_q.push_back(r);
          n_acc++;
        end
        @(posedge c_clk);
        #1;
      end
      req_valid = 1'b0;
      drain();

      f = '{TIMEOUT, 2'd1, 32'd0};
      force_q.push_back(f);
      send_req(4'd3, $urandom, $urandom, 2'd3);
      send_req(4'd4, $urandom, $urandom, 2'd0);
      drain();
      f = '{TIMEOUT - 1, 2'd3, 32'hCAFE_F00D};
      force_q.push_back(f);
      send_req(4'd15, $urandom, $urandom, 2'd2);
      drain();
      f = '{0, 2'd2, 32'hFFFF_FFFF};
      force_q.push_back(f);
      send_req(4'd2, $urandom, $urandom, 2'd1);
      drain();

      for (int n = 0; n < NRAND; n++) begin
        cycles($urandom_range(0, 3));
        send_req(4'($urandom_range(1, 15)), $urandom, $urandom,
                 2'($urandom));
      end
      drain();

      chk(g, "stray_clean", 64'(stray_err), 64'd0);
      poke = 2'd1;
      cycles(1);
      poke = 2'd0;
      cycles(2);
      chk(g, "stray_set", 64'(stray_err), 64'd1);
      cycles(10);
      chk(g, "stray_sticky", {62'd0, stray_err, busy}, 64'h2);

      f = '{TIMEOUT, 2'd1, 32'd0};
      force_q.push_back(f);
      send_req(4'd5, $urandom, $urandom, 2'd1);
      send_req(4'd6, $urandom, $urandom, 2'd2);
      reach_wait();
      cycles(3);
      reset = 1'b1;
      pend_q.delete();
      exp_q.delete();
      cycles(1);
      reset = 1'b0;
      n_acc = n_done;
      chk(g, "midrst_state",
          {60'd0, req_ready, busy, stray_err, rsp_valid}, 64'h8);
      cycles(40);
      chk(g, "midrst_idle", {62'd0, busy, req_ready}, 64'h1);
      done = 1;
    end
  end

  initial begin
    for (int i = 0; i < 30000 && !(lane[0].done && lane[1].done); i++) begin
      @(posedge c_clk);
    end
    if (!(lane[0].done && lane[1].done)) begin
      checks++;
      errors++;
      $display("FAIL global_timeout act=%0d exp=%0d", cyc, 30000);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
